// File: rtl/ucitavanje_uzorka_pkg.sv
// uzorak_pkg: shared sample-loader constants, FSM state type and the feature bit-offset helper
package uzorak_pkg;
    localparam int BROJ_ZNACAJKI   = 60;
    localparam int SIRINA_ZNACAJKE = 16;
    localparam int SIRINA_UZORKA   = BROJ_ZNACAJKI * SIRINA_ZNACAJKE;

    typedef enum logic [1:0] {PUNJENJE, PUN, ODBACIVANJE} stanje_t;

    function automatic int indeks_znacajke(input int k);
        return k * SIRINA_ZNACAJKE;
    endfunction
endpackage

// File: rtl/ucitavanje_uzorka.sv
// ucitavanje_uzorka: double-buffered serial-to-parallel loader, 60 x 16-bit features into a 960-bit sample
//   clk, reset (sync, active-high)
//   znacajka_in/_valid/_zadnja/_ready : feature input handshake, _zadnja marks the last feature
//   uzorak/_valid/_ready              : assembled sample output handshake
//   greska, broj_gresaka              : error pulse and saturating error count
//   optional macro UZORAK_CLAMP_EN    : features with bit 15 set are stored as zero and flagged
module ucitavanje_uzorka
    import uzorak_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              znacajka_in,
    input  logic                     znacajka_valid,
    input  logic                     znacajka_zadnja,
    output logic                     znacajka_ready,
    output logic [SIRINA_UZORKA-1:0] uzorak,
    output logic                     uzorak_valid,
    input  logic                     uzorak_ready,
    output logic                     greska,
    output logic [7:0]               broj_gresaka
);
    stanje_t stanje, sledece;
    logic [5:0] brojac;
    logic [SIRINA_UZORKA-1:0] sjena, sjena_nova;
    logic [15:0] vrednost;
    logic prihvat, predaja, upis, zadnji_slot, kompletan, direktno;
    logic greska_okvira, greska_znaka, dogadjaj_greske;

    assign prihvat       = znacajka_valid && znacajka_ready;
    assign predaja       = uzorak_valid && uzorak_ready;
    assign upis          = prihvat && stanje == PUNJENJE;
    assign zadnji_slot   = brojac == 6'(BROJ_ZNACAJKI - 1);
    assign kompletan     = upis && znacajka_zadnja && zadnji_slot;
    // Output buffer is free if empty or being drained at this very edge.
    assign direktno      = kompletan && (!uzorak_valid || uzorak_ready);
    // Early zadnja or missing zadnja on the final slot are both framing errors.
    assign greska_okvira = upis && (znacajka_zadnja != zadnji_slot);

`ifdef UZORAK_CLAMP_EN
    assign vrednost     = znacajka_in[15] ? 16'h0000 : znacajka_in;
    assign greska_znaka = upis && znacajka_in[15];
`else
    assign vrednost     = znacajka_in;
    assign greska_znaka = 1'b0;
`endif

    // Simultaneous framing and sign errors count as a single event.
    assign dogadjaj_greske = greska_okvira || greska_znaka;

    // Shadow image including this cycle's feature, so a completing sample can be copied out in the same edge.
    for (genvar g = 0; g < BROJ_ZNACAJKI; g++) begin : g_slot
        assign sjena_nova[indeks_znacajke(g) +: SIRINA_ZNACAJKE] =
            (upis && brojac == 6'(g)) ? vrednost : sjena[indeks_znacajke(g) +: SIRINA_ZNACAJKE];
    end

    always_ff @(posedge clk) begin
        if (reset) stanje <= PUNJENJE;
        else       stanje <= sledece;
    end

    always_comb begin
        sledece = stanje;
        case (stanje)
            PUNJENJE:    sledece = (kompletan && !direktno) ? PUN :
                                   (upis && !znacajka_zadnja && zadnji_slot) ? ODBACIVANJE : PUNJENJE;
            PUN:         sledece = predaja ? PUNJENJE : PUN;
            ODBACIVANJE: sledece = (prihvat && znacajka_zadnja) ? PUNJENJE : ODBACIVANJE;
            default:     sledece = PUNJENJE;
        endcase
    end

    always_comb znacajka_ready = !reset && stanje != PUN;

    always_ff @(posedge clk) begin
        if (reset) begin
            sjena        <= '0;
            brojac       <= '0;
            uzorak       <= '0;
            uzorak_valid <= 1'b0;
            greska       <= 1'b0;
            broj_gresaka <= '0;
        end else begin
            sjena        <= sjena_nova;
            // Any accepted zadnja or the final slot ends the frame (good or bad), so the counter restarts.
            brojac       <= (upis && !znacajka_zadnja && !zadnji_slot) ? brojac + 6'd1 :
                            upis ? 6'd0 : brojac;
            uzorak       <= direktno ? sjena_nova :
                            (stanje == PUN && predaja) ? sjena : uzorak;
            uzorak_valid <= direktno || stanje == PUN || (uzorak_valid && !uzorak_ready);
            greska       <= dogadjaj_greske;
            broj_gresaka <= (dogadjaj_greske && broj_gresaka != 8'hFF) ? broj_gresaka + 8'd1 : broj_gresaka;
        end
    end
endmodule

// File: tb/tb_ucitavanje_uzorka.sv
// tb_ucitavanje_uzorka: directed self-checking bench for the sample loader
module tb_ucitavanje_uzorka;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  znacajka_in = '0;
    logic         znacajka_valid = 1'b0;
    logic         znacajka_zadnja = 1'b0;
    logic         znacajka_ready;
    logic [959:0] uzorak;
    logic         uzorak_valid;
    logic         uzorak_ready = 1'b1;
    logic         greska;
    logic [7:0]   broj_gresaka;

    int total = 0, passed = 0, gcnt = 0, vcnt = 0, g0, v0;

    ucitavanje_uzorka dut (
        .clk(clk), .reset(reset), .znacajka_in(znacajka_in), .znacajka_valid(znacajka_valid),
        .znacajka_zadnja(znacajka_zadnja), .znacajka_ready(znacajka_ready), .uzorak(uzorak),
        .uzorak_valid(uzorak_valid), .uzorak_ready(uzorak_ready), .greska(greska),
        .broj_gresaka(broj_gresaka)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (greska) gcnt++;
        if (uzorak_valid) vcnt++;
    end

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    function automatic logic [15:0] sl(input int k);
        return uzorak[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input logic z);
        int n = 0;
        znacajka_in = v;
        znacajka_valid = 1'b1;
        znacajka_zadnja = z;
        while (!znacajka_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("ready_timeout", 16'(znacajka_ready), 16'd1);
        tick();
        znacajka_valid = 1'b0;
        znacajka_zadnja = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] base);
        for (int k = 0; k < 60; k++) send(base + 16'(k), k == 59);
    endtask

    task automatic chk_sample(input string tag, input logic [15:0] base);
        for (int k = 0; k < 60; k++) chk(tag, sl(k), base + 16'(k));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 16'(uzorak_valid), 16'd0);
        chk("rst_uzorak_lo", sl(0), 16'h0000);
        chk("rst_greska", 16'(greska), 16'd0);
        chk("rst_broj", 16'(broj_gresaka), 16'd0);
        chk("rst_ready", 16'(znacajka_ready), 16'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 16'(znacajka_ready), 16'd1);

        send_sample(16'h0001);
        chk("s1_valid", 16'(uzorak_valid), 16'd1);
        chk("s1_first", sl(0), 16'h0001);
        chk("s1_last", sl(59), 16'h003C);
        chk_sample("s1_data", 16'h0001);
        chk("s1_no_greska", 16'(gcnt), 16'd0);
        tick();
        chk("s1_consumed", 16'(uzorak_valid), 16'd0);
        chk("s1_hold", sl(0), 16'h0001);

        uzorak_ready = 1'b0;
        send_sample(16'h0100);
        chk("bb_a_valid", 16'(uzorak_valid), 16'd1);
        chk_sample("bb_a_data", 16'h0100);
        send_sample(16'h0200);
        chk("bb_pun_ready", 16'(znacajka_ready), 16'd0);
        tick();
        tick();
        chk("bb_pun_ready2", 16'(znacajka_ready), 16'd0);
        chk("bb_a_stable", sl(59), 16'h013B);
        chk("bb_a_valid2", 16'(uzorak_valid), 16'd1);
        uzorak_ready = 1'b1;
        tick();
        chk("bb_b_valid", 16'(uzorak_valid), 16'd1);
        chk_sample("bb_b_data", 16'h0200);
        chk("bb_ready_back", 16'(znacajka_ready), 16'd1);
        tick();
        chk("bb_b_consumed", 16'(uzorak_valid), 16'd0);

        g0 = gcnt;
        for (int k = 0; k <= 10; k++) send(16'h0010 + 16'(k), k == 10);
        chk("early_greska", 16'(greska), 16'd1);
        chk("early_broj", 16'(broj_gresaka), 16'd1);
        chk("early_valid", 16'(uzorak_valid), 16'd0);
        tick();
        chk("early_pulse_end", 16'(greska), 16'd0);
        chk("early_one_pulse", 16'(gcnt - g0), 16'd1);
        send_sample(16'h0300);
        chk("early_next_valid", 16'(uzorak_valid), 16'd1);
        chk_sample("early_next_data", 16'h0300);
        tick();
        tick();

        v0 = vcnt;
        g0 = gcnt;
        for (int k = 0; k < 60; k++) send(16'h0400 + 16'(k), 1'b0);
        chk("nolast_greska", 16'(greska), 16'd1);
        chk("nolast_broj", 16'(broj_gresaka), 16'd2);
        chk("nolast_ready", 16'(znacajka_ready), 16'd1);
        for (int k = 0; k < 3; k++) send(16'h0440 + 16'(k), k == 2);
        tick();
        tick();
        chk("nolast_no_valid", 16'(vcnt - v0), 16'd0);
        chk("nolast_one_pulse", 16'(gcnt - g0), 16'd1);
        chk("nolast_broj2", 16'(broj_gresaka), 16'd2);
        chk("nolast_hold", sl(0), 16'h0300);

        g0 = gcnt;
        for (int k = 0; k < 30; k++) send(16'h0500 + 16'(k), 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 16'(uzorak_valid), 16'd0);
        chk("mid_rst_lo", sl(0), 16'h0000);
        chk("mid_rst_hi", sl(59), 16'h0000);
        chk("mid_rst_broj", 16'(broj_gresaka), 16'd0);
        chk("mid_rst_greska", 16'(greska), 16'd0);
        chk("mid_rst_ready", 16'(znacajka_ready), 16'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready2", 16'(znacajka_ready), 16'd1);
        send_sample(16'h0600);
        chk("mid_rst_next_valid", 16'(uzorak_valid), 16'd1);
        chk_sample("mid_rst_next_data", 16'h0600);
        chk("mid_rst_no_err", 16'(gcnt - g0), 16'd0);
        tick();

        g0 = gcnt;
        for (int k = 0; k < 60; k++) send(k == 5 ? 16'h8123 : 16'h0700 + 16'(k), k == 59);
        chk("sign_valid", 16'(uzorak_valid), 16'd1);
        chk("sign_f4", sl(4), 16'h0704);
        chk("sign_f6", sl(6), 16'h0706);
`ifdef UZORAK_CLAMP_EN
        chk("sign_f5", sl(5), 16'h0000);
        chk("sign_pulses", 16'(gcnt - g0), 16'd1);
        chk("sign_broj", 16'(broj_gresaka), 16'd1);
`else
        chk("sign_f5", sl(5), 16'h8123);
        chk("sign_pulses", 16'(gcnt - g0), 16'd0);
        chk("sign_broj", 16'(broj_gresaka), 16'd0);
`endif
        tick();

        for (int k = 0; k < 256; k++) send(16'h0001, 1'b1);
        tick();
        chk("sat_broj", 16'(broj_gresaka), 16'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
